// File: rtl/deserializer.sv
// Serial-to-parallel receive stage: rebuilds MSB-first words of 1..16 bits into a FWFT FIFO.
// Define DESER_LEN_CHECK_EN to discard 1/2-bit words and pulse len_err_o.
`timescale 1ns/1ps
module deserializer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        arst_n_i,
    input  logic        ser_data_i,
    input  logic        ser_data_val_i,
    output logic [15:0] deser_data_o,
    output logic [4:0]  deser_len_o,
    output logic        deser_val_o,
    input  logic        deser_ready_i,
    output logic        busy_o,
    output logic        ovf_o,
    output logic        len_err_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef struct packed {
        logic [4:0]  len;
        logic [15:0] data;
    } word_t;

    logic [15:0] shreg_q, shreg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] bits;
    logic [3:0]  bit_idx;
    logic        done;
    word_t       done_word;
    logic        len_bad;

    logic        cmp_val_q, cmp_val_d;
    word_t       cmp_q, cmp_d;

    word_t       mem_q [FIFO_DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic        empty, full, pop, push;
    logic        ovf_q, ovf_d;
    word_t       head;

    assign bit_idx = 4'd15 - cnt_q[3:0];

    // Bit collection; a word completes on the 16th bit or on the first gap
    always_comb begin
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        bits      = shreg_q;
        done      = 1'b0;
        done_word = '0;
        if (ser_data_val_i) begin
            bits[bit_idx] = ser_data_i;
            if (cnt_q == 5'd15) begin
                done           = 1'b1;
                done_word.len  = 5'd16;
                done_word.data = bits;
                shreg_d        = '0;
                cnt_d          = '0;
            end else begin
                shreg_d = bits;
                cnt_d   = cnt_q + 5'd1;
            end
        end else if (cnt_q != 5'd0) begin
            done           = 1'b1;
            done_word.len  = cnt_q;
            done_word.data = shreg_q;
            shreg_d        = '0;
            cnt_d          = '0;
        end
    end

`ifdef DESER_LEN_CHECK_EN
    assign len_bad = done && (done_word.len <= 5'd2);
`else
    assign len_bad = 1'b0;
`endif

    always_comb begin
        cmp_val_d = done & ~len_bad;
        cmp_d     = cmp_q;
        if (done & ~len_bad) begin
            cmp_d = done_word;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            shreg_q   <= '0;
            cnt_q     <= '0;
            cmp_val_q <= 1'b0;
            cmp_q     <= '0;
        end else begin
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            cmp_val_q <= cmp_val_d;
            cmp_q     <= cmp_d;
        end
    end

    // A pop in the same cycle frees the slot the registered word lands in
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = ~empty & deser_ready_i;
    assign push  = cmp_val_q & (~full | pop);
    assign ovf_d = cmp_val_q & full & ~pop;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_q[AW-1:0]] <= cmp_q;
                wr_q                <= wr_q + PTR_ONE;
            end
            if (pop) begin
                rd_q <= rd_q + PTR_ONE;
            end
            ovf_q <= ovf_d;
        end
    end

`ifdef DESER_LEN_CHECK_EN
    logic lerr_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            lerr_q <= 1'b0;
        end else begin
            lerr_q <= len_bad;
        end
    end

    assign len_err_o = lerr_q;
`else
    assign len_err_o = 1'b0;
`endif

    assign head         = mem_q[rd_q[AW-1:0]];
    assign deser_data_o = head.data;
    assign deser_len_o  = head.len;
    assign deser_val_o  = ~empty;
    assign busy_o       = (cnt_q != 5'd0);
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_deserializer.sv
// Randomised and directed bench for deserializer against a word-level reference model.
`timescale 1ns/1ps
module tb_deserializer;

    localparam int DEPTH = 4;
`ifdef DESER_LEN_CHECK_EN
    localparam bit LCHK = 1'b1;
`else
    localparam bit LCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sd = 1'b0;
    logic        sv = 1'b0;
    logic        rdy = 1'b0;
    logic [15:0] deser_data_o;
    logic [4:0]  deser_len_o;
    logic        deser_val_o;
    logic        busy_o;
    logic        ovf_o;
    logic        len_err_o;

    always #5 clk = ~clk;

    deserializer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .arst_n_i       (rst_n),
        .ser_data_i     (sd),
        .ser_data_val_i (sv),
        .deser_data_o   (deser_data_o),
        .deser_len_o    (deser_len_o),
        .deser_val_o    (deser_val_o),
        .deser_ready_i  (rdy),
        .busy_o         (busy_o),
        .ovf_o          (ovf_o),
        .len_err_o      (len_err_o)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: bit list per frame, one-cycle completion latency, queue FIFO
    logic [20:0] mq[$];
    logic [20:0] obs[$];
    logic [15:0] cur = '0;
    int          cur_len = 0;
    bit          pend_v = 1'b0;
    logic [20:0] pend = '0;
    bit          m_ovf = 1'b0;
    bit          m_lerr = 1'b0;
    bit          m_pop;
    bit          m_done;
    int          ovf_cnt = 0;
    int          lerr_cnt = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                cur = '0; cur_len = 0; pend_v = 1'b0;
                m_ovf = 1'b0; m_lerr = 1'b0;
            end else begin
                if (deser_val_o && rdy) obs.push_back({deser_len_o, deser_data_o});
                if (ovf_o) ovf_cnt++;
                if (len_err_o) lerr_cnt++;
                m_pop = (mq.size() != 0) && rdy;
                m_ovf = 1'b0;
                m_lerr = 1'b0;
                if (m_pop) void'(mq.pop_front());
                if (pend_v) begin
                    if (mq.size() < DEPTH) mq.push_back(pend);
                    else m_ovf = 1'b1;
                end
                pend_v = 1'b0;
                m_done = 1'b0;
                if (sv) begin
                    cur[15 - cur_len] = sd;
                    cur_len++;
                    if (cur_len == 16) m_done = 1'b1;
                end else if (cur_len != 0) begin
                    m_done = 1'b1;
                end
                if (m_done) begin
                    if (LCHK && cur_len <= 2) m_lerr = 1'b1;
                    else begin
                        pend_v = 1'b1;
                        pend = {5'(cur_len), cur};
                    end
                    cur = '0;
                    cur_len = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("val", 32'(deser_val_o), 32'(mq.size() != 0));
                if (mq.size() != 0) begin
                    check("data", 32'(deser_data_o), 32'(mq[0][15:0]));
                    check("len", 32'(deser_len_o), 32'(mq[0][20:16]));
                end
                check("busy", 32'(busy_o), 32'(cur_len != 0));
                check("ovf", 32'(ovf_o), 32'(m_ovf));
                check("len_err", 32'(len_err_o), 32'(m_lerr));
            end
        end
    end

    task automatic cyc(input logic v, input logic b);
        sv = v;
        sd = b;
        @(negedge clk);
        #1;
    endtask

    task automatic frame(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, w[15 - i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    task automatic check_word(input string tag, input int idx, input logic [20:0] exp);
        check(tag, (idx < obs.size()) ? 32'(obs[idx]) : 32'hDEAD_BEEF, 32'(exp));
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_val"}, 32'(deser_val_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_data"}, 32'(deser_data_o), 32'd0);
        check({tag, "_len"}, 32'(deser_len_o), 32'd0);
        check({tag, "_ovf"}, 32'(ovf_o), 32'd0);
        check({tag, "_lerr"}, 32'(len_err_o), 32'd0);
    endtask

    logic [3:0]  nib [6];
    logic [15:0] rw;

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outs("rst");
        rst_n = 1'b1;
        rdy = 1'b1;

        obs.delete();
        frame(16'hA5C3, 16);
        idle(4);
        check("a5c3_cnt", 32'(obs.size()), 32'd1);
        check_word("a5c3_word", 0, {5'd16, 16'hA5C3});

        obs.delete();
        frame(16'hB000, 5);
        idle(1);
        frame(16'hE000, 3);
        idle(4);
        check("short_cnt", 32'(obs.size()), 32'd2);
        check_word("b000_word", 0, {5'd5, 16'hB000});
        check_word("e000_word", 1, {5'd3, 16'hE000});

        obs.delete();
        frame(16'h1234, 16);
        frame(16'hFFFF, 16);
        idle(4);
        check("b2b_cnt", 32'(obs.size()), 32'd2);
        check_word("b2b_w0", 0, {5'd16, 16'h1234});
        check_word("b2b_w1", 1, {5'd16, 16'hFFFF});

        obs.delete();
        rdy = 1'b0;
        ovf_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            nib[i] = 4'($urandom_range(0, 15));
            frame({nib[i], 12'h000}, 4);
            idle(1);
        end
        idle(3);
        check("ovf_cnt", 32'(ovf_cnt), 32'd2);
        check("full_val", 32'(deser_val_o), 32'd1);
        rdy = 1'b1;
        idle(8);
        check("drain_cnt", 32'(obs.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_word("drain_word", i, {5'd4, nib[i], 12'h000});

        frame(16'($urandom), 7);
        rst_n = 1'b0;
        sv = 1'b0;
        #1;
        check_reset_outs("rst_mid");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        rdy = 1'b0;
        frame(16'h9000, 4);
        idle(1);
        frame(16'h6000, 4);
        idle(3);
        check("queued_val", 32'(deser_val_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outs("rst_fifo");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        rdy = 1'b1;
        obs.delete();
        rw = 16'($urandom);
        frame(rw, 16);
        idle(4);
        check("post_rst_cnt", 32'(obs.size()), 32'd1);
        check_word("post_rst_word", 0, {5'd16, rw});

        obs.delete();
        lerr_cnt = 0;
        frame(16'hC000, 2);
        idle(4);
`ifdef DESER_LEN_CHECK_EN
        check("len2_err", 32'(lerr_cnt), 32'd1);
        check("len2_cnt", 32'(obs.size()), 32'd0);
`else
        check("len2_err", 32'(lerr_cnt), 32'd0);
        check("len2_cnt", 32'(obs.size()), 32'd1);
        check_word("len2_word", 0, {5'd2, 16'hC000});
`endif

        for (int i = 0; i < 600; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            cyc(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
        end
        rdy = 1'b1;
        idle(12);
        check("final_empty", 32'(deser_val_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/deserializer.md
# deserializer

Receive-side stage that sits directly downstream of the team's serializer. It samples the serial bit stream (`ser_data` + `ser_data_val`), rebuilds MSB-first words of 1..16 bits, and tags each word with its length. Completed words are buffered in a small first-word-fall-through FIFO with a valid/ready output handshake toward the consumer.

## Interface
- `FIFO_DEPTH`, default 4: word FIFO depth; power of two, ≥2.
- `clk_i`  in  1: clock, all logic on rising edge.
- `arst_n_i`  in  1: reset, asynchronous assert, active-low; deassertion synchronised externally.
- `ser_data_i`  in  1: serial bit, MSB first.
- `ser_data_val_i`  in  1: bit valid; a frame is a contiguous run of high cycles.
- `deser_data_o`  out  16: head word, left-aligned (first bit in [15]); unused LSBs are 0.
- `deser_len_o`  out  5: head word length, 1..16.
- `deser_val_o`  out  1: FIFO not empty.
- `deser_ready_i`  in  1: consumer accepts the head word when high together with `deser_val_o`.
- `busy_o`  out  1: a frame is partially collected (bit count ≠ 0).
- `ovf_o`  out  1: one-cycle pulse; a completed word was dropped because the FIFO was full.
- `len_err_o`  out  1: one-cycle pulse; see Configuration.

## Operation
- Reset: shift register, bit count, FIFO pointers and storage, and `ovf_o`/`len_err_o` all clear to 0. Outputs are 0 on reset: `deser_val_o`=0, `busy_o`=0, `deser_data_o`=0, `deser_len_o`=0. Reset mid-frame discards the partial word. Reset with FIFO contents discards the contents.
- Collect: on each cycle with `ser_data_val_i`=1:
  - shreg[15-cnt] <= `ser_data_i`;
  - cnt <= cnt+1. cnt is 5 bits, range 0..16.
- Word completes:
  - (a) on the cycle the 16th bit is accepted; the pushed word includes that bit and len=16, then cnt→0;
  - (b) on the first cycle with `ser_data_val_i`=0 while cnt≠0; len=cnt, then cnt→0.
- Back-to-back: after a 16-bit completion, `ser_data_val_i` still high the next cycle starts a new frame with no gap required. A 17-bit-long high run therefore yields one 16-bit word and one word of length 1.
- On completion, shreg clears so the next word has zero LSBs.
- Push: a completed word is written to the FIFO if not full. If full, the word is dropped and `ovf_o` pulses on the following cycle. A pop in the same cycle as the push frees a slot, so a push into a full FIFO with a simultaneous pop is accepted and `ovf_o` stays 0.
- Pop: when `deser_val_o` & `deser_ready_i`, the read pointer advances. Head data/len are driven from FIFO storage (FWFT).
- Pointers are log2(FIFO_DEPTH)+1 bits wide. Full/empty are decided by comparing the MSB and the remaining bits; pointers wrap naturally.
- `deser_data_o`/`deser_len_o` are don't-care while `deser_val_o`=0 and hold stable while `deser_val_o`=1 & `deser_ready_i`=0.

## Timing
- Case (a): 16th bit sampled at edge N → word visible (`deser_val_o`=1) after edge N+1 if the FIFO was empty.
- Case (b): last bit at edge N, gap sampled at edge N+1 → visible after edge N+2.
- Throughput: one word per cycle on pop; sustained input of one bit per cycle never overflows if the consumer keeps `deser_ready_i` high.
- `busy_o` is high from the cycle after the first bit until the cycle after completion.
- `ovf_o`/`len_err_o` are registered, high for exactly one cycle per event.

## Configuration
- `DESER_LEN_CHECK_EN` defined: completed words with len 1 or 2 (never emitted by the serializer) are discarded, never pushed, and `len_err_o` pulses one cycle. A discarded word never raises `ovf_o`.
- Not defined: `len_err_o` is tied 0, and len 1/2 words are pushed like any other word.

## Test plan
- 16 high cycles carrying 0xA5C3 MSB first, `deser_ready_i`=1 → one word 0xA5C3, len=16, `deser_val_o` high for 1 cycle.
- 5 bits 1,0,1,1,0 then gap → word 0xB000, len=5. A following 3-bit frame 1,1,1 → 0xE000, len=3.
- 32 contiguous high cycles (0x1234 then 0xFFFF) → two words, with no bit lost at the boundary.
- `deser_ready_i`=0 with FIFO_DEPTH=4, six 4-bit frames → first four words held in order, `ovf_o` pulses twice. Raising ready then drains exactly four words.
- Reset asserted after 7 bits of a frame, and after that frame with 2 words queued → `busy_o`=0, `deser_val_o`=0 immediately. A subsequent 16-bit frame is decoded correctly.
- 2-bit frame 1,1: with `DESER_LEN_CHECK_EN` → no word, `len_err_o` pulses once. Without it → word 0xC000, len=2, `len_err_o`=0.
